// File: rtl/regmux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regmux_arb_pkg
// Brief    : Shared mode encodings and select-width helper for regmux_arb.
// Revision : 1.0  initial release
// ============================================================================
package regmux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width needed to index n channels; a single bit is kept even for n<=2.
    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : regmux_arb_pkg
`default_nettype wire

// File: rtl/regmux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin search: first set req bit after ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import regmux_arb_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int SELW = 1
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NCH]) begin
                found = 1'b1;
                idx   = SELW'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regmux_arb.sv
`default_nettype none
// ============================================================================
// Module   : regmux_arb
// Brief    : Registered N-channel selector, fixed-select or round-robin,
//            with a one-entry valid/ready output register.
// Revision : 1.0  initial release
// ============================================================================
module regmux_arb
    import regmux_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int SELW  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        grant
);

    localparam int PADN = 2 ** SELW;

    if (SELW != sel_width(NCH)) begin : g_selw_bad
        $error("regmux_arb: SELW=%0d must equal %0d for NCH=%0d",
               SELW, sel_width(NCH), NCH);
    end

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  grant_q;
    logic [SELW-1:0]  rr_ptr_q;

    logic             w_can_take;
    logic             w_rr_found;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_fix_ok;
    logic [SELW-1:0]  w_cand;
    logic             w_cand_ok;
    logic [PADN-1:0]  w_valid_pad;
    logic             w_take;
    logic [WIDTH-1:0] w_word;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    assign w_can_take  = !out_valid_q || out_ready;
    assign w_fix_ok    = (32'(sel) < 32'(NCH));
    assign w_cand      = (mode == MODE_RR) ? w_rr_idx   : sel;
    assign w_cand_ok   = (mode == MODE_RR) ? w_rr_found : w_fix_ok;
    // Padding lets an out-of-range fixed select index safely; w_cand_ok masks it.
    assign w_valid_pad = PADN'(in_valid);
    assign w_take      = w_can_take && w_cand_ok && w_valid_pad[w_cand] && !reset;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_cand == SELW'(i)) begin
                w_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_take && (w_cand == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            rr_ptr_q    <= SELW'(NCH - 1);
        end else if (w_take) begin
            out_data_q  <= w_word;
            out_valid_q <= 1'b1;
            grant_q     <= w_cand;
            if (mode == MODE_RR) begin
                rr_ptr_q <= w_cand;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;

endmodule : regmux_arb
`default_nettype wire

// File: tb/tb_regmux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regmux_arb
// Brief    : Directed self-checking bench for regmux_arb (NCH = 2, 3, 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_regmux_arb;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // NCH=2 instance
    logic [31:0] d2;
    logic [1:0]  v2, r2;
    logic        m2, or2, ov2;
    logic [0:0]  s2, g2;
    logic [15:0] od2;

    // NCH=4 instance
    logic [63:0] d4;
    logic [3:0]  v4, r4;
    logic        m4, or4, ov4;
    logic [1:0]  s4, g4;
    logic [15:0] od4;

    // NCH=3 instance
    logic [47:0] d3;
    logic [2:0]  v3, r3;
    logic        m3, or3, ov3;
    logic [1:0]  s3, g3;
    logic [15:0] od3;

    regmux_arb #(.WIDTH(16), .NCH(2), .SELW(1)) u2 (
        .clock(clk), .reset(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .mode(m2), .sel(s2), .out_data(od2), .out_valid(ov2),
        .out_ready(or2), .grant(g2)
    );

    regmux_arb #(.WIDTH(16), .NCH(4), .SELW(2)) u4 (
        .clock(clk), .reset(rst), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .mode(m4), .sel(s4), .out_data(od4), .out_valid(ov4),
        .out_ready(or4), .grant(g4)
    );

    regmux_arb #(.WIDTH(16), .NCH(3), .SELW(2)) u3 (
        .clock(clk), .reset(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .mode(m3), .sel(s3), .out_data(od3), .out_valid(ov3),
        .out_ready(or3), .grant(g3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d2 = {16'h0062, 16'h0061}; v2 = 2'b11; m2 = 1'b0; s2 = 1'b0; or2 = 1'b0;
        d4 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        v4 = 4'b1111; m4 = 1'b1; s4 = 2'd3; or4 = 1'b0;
        d3 = {16'h3002, 16'h3001, 16'h3000}; v3 = 3'b111; m3 = 1'b0; s3 = 2'd0; or3 = 1'b0;

        // Reset held two clocks with every channel valid
        tick();
        tick();
        chk("rst_ov4", ov4, 0);
        chk("rst_od4", od4, 0);
        chk("rst_g4",  g4, 0);
        chk("rst_r4",  r4, 0);
        chk("rst_r2",  r2, 0);
        chk("rst_ov2", ov2, 0);
        rst = 1'b0;
        v4 = 4'b0000;
        v3 = 3'b000;

        // FIXED select, NCH=2
        or2 = 1'b1;
        #1 chk("fix_r2_sel0", r2, 2'b01);
        tick();
        chk("fix_ov_sel0", ov2, 1);
        chk("fix_od_sel0", od2, 16'h0061);
        chk("fix_g_sel0",  g2, 0);
        s2 = 1'b1;
        tick();
        chk("fix_od_sel1", od2, 16'h0062);
        chk("fix_g_sel1",  g2, 1);

        // Backpressure, then drain with same-cycle refill
        or2 = 1'b0;
        s2  = 1'b0;
        #1 chk("bp_r2", r2, 2'b00);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_od", od2, 16'h0062);
            chk("bp_ov", ov2, 1);
            chk("bp_rdy", r2, 2'b00);
        end
        or2 = 1'b1;
        #1 chk("bp_refill_r2", r2, 2'b01);
        tick();
        chk("bp_refill_ov", ov2, 1);
        chk("bp_refill_od", od2, 16'h0061);
        chk("bp_refill_g",  g2, 0);

        // Round-robin NCH=4, all valid, sel ignored
        v4  = 4'b1111;
        or4 = 1'b1;
        #1 chk("rr_first_r4", r4, 4'b0001);
        tick();
        chk("rr_g0", g4, 0);
        chk("rr_d0", od4, 16'h1000);
        tick();
        chk("rr_g1", g4, 1);
        chk("rr_d1", od4, 16'h1001);
        tick();
        chk("rr_g2", g4, 2);
        chk("rr_d2", od4, 16'h1002);
        tick();
        chk("rr_g3", g4, 3);
        chk("rr_d3", od4, 16'h1003);
        tick();
        chk("rr_wrap_g0", g4, 0);
        chk("rr_wrap_ov", ov4, 1);

        // Single valid channel re-granted every cycle
        v4 = 4'b0100;
        #1 chk("rr_single_r4", r4, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rr_single_g", g4, 2);
            chk("rr_single_ov", ov4, 1);
        end

        // FIXED out-of-range select, NCH=3
        v3  = 3'b111;
        or3 = 1'b1;
        tick();
        chk("oor_pre_ov", ov3, 1);
        chk("oor_pre_od", od3, 16'h3000);
        s3 = 2'd3;
        #1 chk("oor_r3", r3, 3'b000);
        tick();
        chk("oor_ov_fall", ov3, 0);
        chk("oor_od_hold", od3, 16'h3000);
        chk("oor_g_hold",  g3, 0);
        tick();
        chk("oor_ov_stay", ov3, 0);

        // Reset mid-operation under backpressure
        or4 = 1'b0;
        v4  = 4'b1111;
        tick();
        chk("mid_pre_ov", ov4, 1);
        chk("mid_pre_g",  g4, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_ov", ov4, 0);
        chk("mid_rst_od", od4, 0);
        chk("mid_rst_g",  g4, 0);
        rst = 1'b0;
        or4 = 1'b1;
        #1 chk("mid_post_r4", r4, 4'b0001);
        tick();
        chk("mid_post_g",  g4, 0);
        chk("mid_post_od", od4, 16'h1000);
        chk("mid_post_ov", ov4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regmux_arb
`default_nettype wire
